// File: rtl/cmm_eb_pkg.sv
// Shared sizing helpers and the parameter-legality check for the N-slot elastic buffer.
`ifndef CMM_EB_PKG_SV
`define CMM_EB_PKG_SV

// Stops elaboration when DEPTH or AFULL_TH is outside its legal range.
`define CMM_EB_CHECK_PARAMS(depth, th) \
  if (((depth) < 2) || ((th) < 1) || ((th) > (depth))) begin : g_illegal_params \
    $fatal(1, "cmm_eb: illegal DEPTH/AFULL_TH combination"); \
  end

package cmm_eb_pkg;

  function automatic int unsigned CNT_W(int unsigned d);
    return unsigned'($clog2(d + 1));
  endfunction

  function automatic int unsigned PTR_W(int unsigned d);
    return (d <= 2) ? 1 : unsigned'($clog2(d - 1));
  endfunction

endpackage

`endif

// File: rtl/cmm_eb_ring.sv
// DEPTH-1 entry storage ring behind the head register; pointers wrap by compare.
module cmm_eb_ring
  import cmm_eb_pkg::*;
#(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data
);

  localparam int unsigned PW    = PTR_W(DEPTH);
  localparam int unsigned SLOTS = DEPTH - 1;

  logic [DWIDTH-1:0] mem [SLOTS];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;

  function automatic logic [PW-1:0] bump(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 2)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= bump(wr_ptr_q);
      if (rd_en) rd_ptr_q <= bump(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];

endmodule

// File: rtl/cmm_nslots_eb.sv
// N-slot elastic buffer: registered head stage plus a DEPTH-1 entry ring, all outputs from flops.
module cmm_nslots_eb
  import cmm_eb_pkg::*;
#(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AFULL_TH = DEPTH - 1
) (
  input  logic                       i_clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic [DWIDTH-1:0]          i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [DWIDTH-1:0]          o_data,
  input  logic                       i_ready,
  output logic [CNT_W(DEPTH)-1:0]    o_count,
  output logic                       o_afull
);

  localparam int unsigned CW = CNT_W(DEPTH);

  `CMM_EB_CHECK_PARAMS(DEPTH, AFULL_TH)

  logic              valid_q, ready_q, afull_q;
  logic [DWIDTH-1:0] data_q, ring_data;
  logic [CW-1:0]     count_q, count_d, ring_cnt;
  logic              push, pop, head_load, ring_nonempty, ring_wr, ring_rd;

  assign push = i_valid & ready_q;
  assign pop  = valid_q & i_ready;

  // The head is always filled first, so the ring holds whatever the head does not.
  assign ring_cnt      = count_q - CW'(valid_q);
  assign ring_nonempty = (ring_cnt != '0);
  assign head_load     = ~valid_q | pop;
  assign ring_rd       = head_load & ring_nonempty;
  assign ring_wr       = push & ~(head_load & ~ring_nonempty);

  assign count_d = count_q + CW'(push) - CW'(pop);

  cmm_eb_ring #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH)
  ) u_ring (
    .clk     (i_clk),
    .rst     (rst),
    .flush   (i_flush),
    .wr_en   (ring_wr),
    .wr_data (i_data),
    .rd_en   (ring_rd),
    .rd_data (ring_data)
  );

  always_ff @(posedge i_clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      afull_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      afull_q <= (AFULL_TH == 0);
      count_q <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < CW'(DEPTH));
      afull_q <= (count_d >= CW'(AFULL_TH));
      if (head_load) begin
        valid_q <= ring_nonempty | push;
        if (ring_nonempty) begin
          data_q <= ring_data;
        end else if (push) begin
          data_q <= i_data;
        end
      end
    end
  end

  assign o_valid = valid_q;
  assign o_ready = ready_q;
  assign o_afull = afull_q;
  assign o_data  = data_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_cmm_nslots_eb.sv
// Random and directed stimulus for a DEPTH=4 and a DEPTH=3 buffer against queue-based models.
module tb_cmm_nslots_eb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_flush, a_ivalid, a_iready, a_oready, a_ovalid, a_afull;
  logic [15:0] a_idata, a_odata;
  logic [2:0]  a_count;
  logic        b_flush, b_ivalid, b_iready, b_oready, b_ovalid, b_afull;
  logic [15:0] b_idata, b_odata;
  logic [1:0]  b_count;

  cmm_nslots_eb #(.DWIDTH(16), .DEPTH(4)) u_dut_a (
    .i_clk   (clk),
    .rst     (rst),
    .i_flush (a_flush),
    .i_valid (a_ivalid),
    .i_data  (a_idata),
    .o_ready (a_oready),
    .o_valid (a_ovalid),
    .o_data  (a_odata),
    .i_ready (a_iready),
    .o_count (a_count),
    .o_afull (a_afull)
  );

  cmm_nslots_eb #(.DWIDTH(16), .DEPTH(3)) u_dut_b (
    .i_clk   (clk),
    .rst     (rst),
    .i_flush (b_flush),
    .i_valid (b_ivalid),
    .i_data  (b_idata),
    .o_ready (b_oready),
    .o_valid (b_ovalid),
    .o_data  (b_odata),
    .i_ready (b_iready),
    .o_count (b_count),
    .o_afull (b_afull)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Models: a queue of buffered beats; "live" is low until the first cycle out of reset.
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  bit          la, lb, rst_last;
  bit          a_acc, b_acc;
  logic [15:0] b_seq;
  int          beef_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    a_acc = 1'b0;
    b_acc = 1'b0;
    if (rst) begin
      qa.delete();
      qb.delete();
      la       = 1'b0;
      lb       = 1'b0;
      rst_last = 1'b1;
    end else begin
      rst_last = 1'b0;
      if (a_flush) begin
        qa.delete();
      end else begin
        if (a_ovalid && a_iready && a_odata == 16'hBEEF) beef_seen++;
        a_acc = a_ivalid && la && (qa.size() < 4);
        if (qa.size() > 0 && a_iready) void'(qa.pop_front());
        if (a_acc) qa.push_back(a_idata);
      end
      if (b_flush) begin
        qb.delete();
      end else begin
        b_acc = b_ivalid && lb && (qb.size() < 3);
        if (qb.size() > 0 && b_iready) void'(qb.pop_front());
        if (b_acc) qb.push_back(b_idata);
      end
      la = 1'b1;
      lb = 1'b1;
    end
  endtask

  task automatic check_outputs();
    check_eq("a_valid", 32'(a_ovalid), 32'(qa.size() > 0));
    check_eq("a_count", 32'(a_count), 32'(qa.size()));
    check_eq("a_ready", 32'(a_oready), 32'(la && qa.size() < 4));
    check_eq("a_afull", 32'(a_afull), 32'(qa.size() >= 3));
    if (rst_last) check_eq("a_data_rst", 32'(a_odata), 32'h0);
    else if (qa.size() > 0) check_eq("a_data", 32'(a_odata), 32'(qa[0]));
    check_eq("b_valid", 32'(b_ovalid), 32'(qb.size() > 0));
    check_eq("b_count", 32'(b_count), 32'(qb.size()));
    check_eq("b_ready", 32'(b_oready), 32'(lb && qb.size() < 3));
    check_eq("b_afull", 32'(b_afull), 32'(qb.size() >= 2));
    if (rst_last) check_eq("b_data_rst", 32'(b_odata), 32'h0);
    else if (qb.size() > 0) check_eq("b_data", 32'(b_odata), 32'(qb[0]));
  endtask

  // B runs a random stream throughout; a beat is held until the model says it was taken.
  task automatic b_stim();
    if (b_acc) b_seq++;
    if (b_acc || !b_ivalid) b_ivalid = 1'($urandom_range(0, 1));
    b_idata  = b_seq;
    b_iready = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    b_stim();
  endtask

  task automatic push_a(input logic [15:0] d);
    int n = 0;
    a_idata  = d;
    a_ivalid = 1'b1;
    do begin
      tick();
      n++;
    end while (!a_acc && n < 20);
    check_eq("a_push_done", 32'(a_acc), 32'h1);
    a_ivalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_ivalid = 1'b0; a_iready = 1'b0; a_idata = '0;
    b_flush = 1'b0; b_ivalid = 1'b0; b_iready = 1'b0; b_idata = '0;
    b_seq = 16'h1;
    la = 1'b0; lb = 1'b0; rst_last = 1'b0; beef_seen = 0;

    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Fill with the sink stalled, then drain in order.
    for (int k = 1; k <= 4; k++) push_a(16'(k));
    repeat (2) tick();
    a_iready = 1'b1;
    repeat (5) tick();

    // Streaming at full rate.
    a_ivalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a_idata = 16'(16'h100 + i);
      tick();
    end
    a_ivalid = 1'b0;
    repeat (3) tick();

    // Full, one-cycle pop pulse with a beat waiting upstream.
    a_iready = 1'b0;
    for (int k = 0; k < 4; k++) push_a(16'($urandom));
    a_ivalid = 1'b1;
    a_idata  = 16'($urandom);
    a_iready = 1'b1;
    tick();
    a_iready = 1'b0;
    repeat (3) tick();
    a_ivalid = 1'b0;

    // Flush at count 3 with a beat offered in the same cycle.
    a_iready = 1'b1;
    tick();
    a_iready = 1'b0;
    a_flush  = 1'b1;
    a_ivalid = 1'b1;
    a_idata  = 16'hBEEF;
    tick();
    a_flush  = 1'b0;
    a_ivalid = 1'b0;
    a_iready = 1'b1;
    repeat (4) tick();

    // Reset with two beats buffered.
    a_iready = 1'b0;
    push_a(16'hA001);
    push_a(16'hA002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    a_iready = 1'b1;
    repeat (4) tick();
    check_eq("beef_never_out", 32'(beef_seen), 32'h0);

    // Random traffic on both buffers, with occasional flushes on A.
    for (int i = 0; i < 250; i++) begin
      if (a_acc || !a_ivalid) begin
        a_ivalid = 1'($urandom_range(0, 1));
        a_idata  = 16'($urandom);
      end
      a_iready = 1'($urandom_range(0, 1));
      a_flush  = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
